pc_epc_reg: RTL and testbench

PC_EPC_REG -- requirements
Module: pc_epc_reg

---
 rtl/pc_epc_reg.sv | 95 +++++++++
 tb/tb_pc_epc_reg.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_epc_reg.sv
// Program counter with exception PC/cause capture and a byte-vectored handler fetch.
// Optional macro PC_ALIGN_CHECK_EN turns misaligned RUN-state PC writes into cause-3 exceptions.
module pc_epc_reg (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] next_pc,
  input  logic        pc_write,
  input  logic        pc_write_cond,
  input  logic        zero,
  input  logic        exc_req,
  input  logic [1:0]  exc_cause,
  input  logic [7:0]  vec_byte,
  input  logic        vec_valid,
  output logic [31:0] pc,
  output logic [31:0] epc,
  output logic [1:0]  cause,
  output logic [31:0] vec_addr,
  output logic        exc_busy
);

  localparam logic [1:0] StRun    = 2'd0;
  localparam logic [1:0] StSave   = 2'd1;
  localparam logic [1:0] StVector = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] epc_q, epc_d;
  logic [1:0]  cause_q, cause_d;

  logic wr_req;
  logic misalign;
  logic take_exc;

  assign wr_req = pc_write | (pc_write_cond & zero);

`ifdef PC_ALIGN_CHECK_EN
  assign misalign = wr_req & (next_pc[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign take_exc = exc_req | misalign;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    cause_d = cause_q;
    case (state_q)
      StRun: begin
        if (take_exc) begin
          // An explicit request wins the cause over an alignment fault in the same cycle.
          epc_d   = pc_q - 32'd4;
          cause_d = exc_req ? exc_cause : 2'd3;
          state_d = StSave;
        end else if (wr_req) begin
          pc_d = next_pc;
        end
      end
      StSave: begin
        state_d = StVector;
      end
      StVector: begin
        if (vec_valid) begin
          pc_d    = {24'b0, vec_byte};
          state_d = StRun;
        end
      end
      default: begin
        state_d = StRun;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StRun;
      pc_q    <= 32'd0;
      epc_q   <= 32'd0;
      cause_q <= 2'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
    end
  end

  assign pc       = pc_q;
  assign epc      = epc_q;
  assign cause    = cause_q;
  assign vec_addr = 32'd253 + {30'b0, cause_q};
  assign exc_busy = (state_q != StRun);

endmodule

// File: tb/tb_pc_epc_reg.sv
// Randomized scoreboard bench for pc_epc_reg: driver pushes model predictions, monitor compares.
module tb_pc_epc_reg;

  logic        clk;
  logic        reset;
  logic [31:0] next_pc;
  logic        pc_write;
  logic        pc_write_cond;
  logic        zero;
  logic        exc_req;
  logic [1:0]  exc_cause;
  logic [7:0]  vec_byte;
  logic        vec_valid;
  logic [31:0] pc;
  logic [31:0] epc;
  logic [1:0]  cause;
  logic [31:0] vec_addr;
  logic        exc_busy;

  pc_epc_reg dut (
    .clk          (clk),
    .reset        (reset),
    .next_pc      (next_pc),
    .pc_write     (pc_write),
    .pc_write_cond(pc_write_cond),
    .zero         (zero),
    .exc_req      (exc_req),
    .exc_cause    (exc_cause),
    .vec_byte     (vec_byte),
    .vec_valid    (vec_valid),
    .pc           (pc),
    .epc          (epc),
    .cause        (cause),
    .vec_addr     (vec_addr),
    .exc_busy     (exc_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] epc;
    logic [1:0]  cause;
    logic [31:0] vec_addr;
    logic        busy;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  // Reference model: phase counts cycles since exception entry (0 = running normally).
  int          m_phase;
  logic [31:0] m_pc, m_epc;
  int          m_cause;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act === expv) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_pc    = 0;
    m_epc   = 0;
    m_cause = 0;
  endtask

  function automatic exp_t model_snapshot();
    exp_t e;
    e.pc       = m_pc;
    e.epc      = m_epc;
    e.cause    = 2'(m_cause);
    e.vec_addr = 32'(253 + m_cause);
    e.busy     = (m_phase != 0);
    return e;
  endfunction

  task automatic cycle(input logic pw, input logic pwc, input logic z, input logic er,
                       input logic [1:0] ec, input logic [31:0] np, input logic [7:0] vb,
                       input logic vv);
    bit want_write;
    bit bad_align;
    @(negedge clk);
    pc_write = pw; pc_write_cond = pwc; zero = z; exc_req = er;
    exc_cause = ec; next_pc = np; vec_byte = vb; vec_valid = vv;
    want_write = pw || (pwc && z);
`ifdef PC_ALIGN_CHECK_EN
    bad_align = want_write && (np % 4 != 0);
`else
    bad_align = 1'b0;
`endif
    if (m_phase == 0) begin
      if (er || bad_align) begin
        m_epc   = m_pc - 32'd4;
        m_cause = er ? int'(ec) : 3;
        m_phase = 1;
      end else if (want_write) begin
        m_pc = np;
      end
    end else if (m_phase == 1) begin
      m_phase = 2;
    end else if (vv) begin
      m_pc    = 32'(vb);
      m_phase = 0;
    end
    exp_q.push_back(model_snapshot());
  endtask

  // Monitor: every clock edge yields one observation to compare against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc", pc, e.pc);
        chk("epc", epc, e.epc);
        chk("cause", 32'(cause), 32'(e.cause));
        chk("vec_addr", vec_addr, e.vec_addr);
        chk("exc_busy", 32'(exc_busy), 32'(e.busy));
      end
    end
  end

  task automatic check_reset_values(input string tag);
    chk({tag, "_pc"}, pc, 32'h0);
    chk({tag, "_epc"}, epc, 32'h0);
    chk({tag, "_cause"}, 32'(cause), 32'h0);
    chk({tag, "_vec_addr"}, vec_addr, 32'd253);
    chk({tag, "_busy"}, 32'(exc_busy), 32'h0);
  endtask

  initial begin
    reset = 1'b0;
    next_pc = 0; pc_write = 0; pc_write_cond = 0; zero = 0;
    exc_req = 0; exc_cause = 0; vec_byte = 0; vec_valid = 0;
    model_reset();
    #1;
    check_reset_values("por");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Directed sequence: plain write, conditional write, exception with priority, vector wait.
    cycle(1, 0, 0, 0, 2'd0, 32'h4,  8'h0, 0);
    cycle(0, 1, 0, 0, 2'd0, 32'h40, 8'h0, 0);
    cycle(0, 1, 1, 0, 2'd0, 32'h40, 8'h0, 0);
    cycle(1, 0, 0, 0, 2'd0, 32'h20, 8'h0, 0);
    cycle(1, 0, 0, 1, 2'd1, 32'h64, 8'h0, 0);
    cycle(0, 0, 0, 0, 2'd0, 32'h0,  8'h0, 0);
    for (int i = 0; i < 10; i++) cycle(i[0], 1, 1, i[1], 2'd2, 32'h1000, 8'h55, 0);
    cycle(0, 0, 0, 0, 2'd0, 32'h0, 8'h90, 1);
    @(posedge clk); #2;
    chk("dir_pc_after_vector", pc, 32'h90);
    chk("dir_epc", epc, 32'h1C);

    // Wrap-around: exception at pc = 0.
    cycle(1, 0, 0, 0, 2'd0, 32'h0, 8'h0, 0);
    cycle(0, 0, 0, 1, 2'd0, 32'h0, 8'h0, 0);
    cycle(0, 0, 0, 0, 2'd0, 32'h0, 8'h0, 0);
    cycle(0, 0, 0, 0, 2'd0, 32'h0, 8'h10, 1);

`ifdef PC_ALIGN_CHECK_EN
    cycle(1, 0, 0, 0, 2'd0, 32'h8,  8'h0, 0);
    cycle(1, 0, 0, 0, 2'd0, 32'h42, 8'h0, 0);
    cycle(0, 0, 0, 0, 2'd0, 32'h0,  8'h0, 0);
    cycle(0, 0, 0, 0, 2'd0, 32'h0,  8'h20, 1);
`endif

    // Randomized traffic through all phases.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] np;
      np = $urandom;
      if ($urandom_range(0, 3) != 0) np[1:0] = 2'b00;
      cycle(1'($urandom_range(0, 2) == 0), 1'($urandom), 1'($urandom),
            1'($urandom_range(0, 7) == 0), 2'($urandom_range(0, 2)), np,
            8'($urandom), 1'($urandom_range(0, 3) == 0));
    end

    // Abort an exception with an asynchronous reset while in the vector phase.
    cycle(0, 0, 0, 0, 2'd0, 32'h0, 8'h0, 1);
    cycle(0, 0, 0, 0, 2'd0, 32'h0, 8'h0, 1);
    cycle(0, 0, 0, 1, 2'd2, 32'h0, 8'h0, 0);
    cycle(0, 0, 0, 0, 2'd0, 32'h0, 8'h0, 0);
    cycle(0, 0, 0, 0, 2'd0, 32'h0, 8'h0, 0);
    @(posedge clk); #2;
    chk("pre_reset_busy", 32'(exc_busy), 32'h1);
    reset = 1'b0;
    #1;
    check_reset_values("async");
    model_reset();
    @(negedge clk);
    #1;
    reset = 1'b1;
    cycle(1, 0, 0, 0, 2'd0, 32'h4, 8'h0, 0);
    cycle(0, 0, 0, 0, 2'd0, 32'h0, 8'h0, 0);

    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
